// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, next-PC select encoding and helper for the
//               fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    // Source of the next fetch address, in priority order of the redirects
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_JREG   = 2'd2,
        SEL_BRANCH = 2'd3
    } pc_sel_e;

    // Sign-extend a word-granular branch offset to PC width
    function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
// ============================================================================
// Module      : next_pc_sel
// Description : Combinational next-PC select and adders. Redirect controls
//               are only honoured when the decode slot holds a live
//               instruction. All arithmetic wraps modulo 2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  ir_pc,
    input  logic             ir_valid,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic             branch,
    input  logic             zero,
    input  logic             inv_zero,
    input  logic [TGT_W-1:0] target_instr,
    input  logic [IMM_W-1:0] imm16,
    input  logic [PC_W-1:0]  jump_word,
    output logic [PC_W-1:0]  next_pc,
    output logic             redirect
);

    pc_sel_e         w_sel;
    logic            w_branch_taken;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_jump_pc;
    logic [PC_W-1:0] w_branch_pc;

    assign w_branch_taken = branch & (zero ^ inv_zero);
    assign w_seq_pc       = pc + PC_W'(1);
    assign w_jump_pc      = {ir_pc[PC_W-1:TGT_W], target_instr};
    assign w_branch_pc    = ir_pc + sext_imm(imm16) + PC_W'(1);

    // Priority select: jump > jump_reg > taken branch > sequential
    always_comb begin
        w_sel = SEL_SEQ;
        if (ir_valid) begin
            if (jump)
                w_sel = SEL_JUMP;
            else if (jump_reg)
                w_sel = SEL_JREG;
            else if (w_branch_taken)
                w_sel = SEL_BRANCH;
        end
    end

    // Next fetch address mux
    always_comb begin
        next_pc = w_seq_pc;
        case (w_sel)
            SEL_JUMP:   next_pc = w_jump_pc;
            SEL_JREG:   next_pc = jump_word;
            SEL_BRANCH: next_pc = w_branch_pc;
            default:    next_pc = w_seq_pc;
        endcase
    end

    assign redirect = (w_sel != SEL_SEQ);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Single-stage instruction fetch. Holds PC and the fetched
//               instruction register; one-cycle fetch latency; stall freezes
//               everything. Optional macro FETCH_DELAY_SLOT_EN keeps the
//               instruction fetched alongside a redirect as a delay slot
//               instead of flushing it, and moves the link address by one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 30'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic               branch,
    input  logic               zero,
    input  logic               inv_zero,
    input  logic [TGT_W-1:0]   target_instr,
    input  logic [IMM_W-1:0]   imm16,
    input  logic [31:0]        jump_to,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    pc_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic [31:0]        link_addr
);

`ifdef FETCH_DELAY_SLOT_EN
    // Return skips over the delay slot
    localparam logic [PC_W-1:0] c_link_ofs = PC_W'(2);
`else
    localparam logic [PC_W-1:0] c_link_ofs = PC_W'(1);
`endif

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_ir_pc;
    logic               r_ir_valid;

    logic [PC_W-1:0]    w_next_pc;
    logic               w_redirect;
    logic [PC_W-1:0]    w_link_word;
    logic               w_unused_jump_lsbs;

    // Register target is a byte address; the low two bits carry no meaning
    assign w_unused_jump_lsbs = ^jump_to[1:0];

    next_pc_sel u_next_pc_sel (
        .pc           (r_pc),
        .ir_pc        (r_ir_pc),
        .ir_valid     (r_ir_valid),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .branch       (branch),
        .zero         (zero),
        .inv_zero     (inv_zero),
        .target_instr (target_instr),
        .imm16        (imm16),
        .jump_word    (jump_to[31:2]),
        .next_pc      (w_next_pc),
        .redirect     (w_redirect)
    );

    // Fetch state update: reset beats stall, stall freezes, otherwise advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (!stall) begin
            r_ir    <= instr_in;
            r_ir_pc <= r_pc;
            r_pc    <= w_next_pc;
`ifdef FETCH_DELAY_SLOT_EN
            r_ir_valid <= 1'b1;
`else
            r_ir_valid <= ~w_redirect;
`endif
        end
    end

    assign w_link_word = r_ir_pc + c_link_ofs;

    assign pc_addr     = r_pc;
    assign instr_out   = r_ir;
    assign instr_pc    = r_ir_pc;
    assign instr_valid = r_ir_valid;
    assign link_addr   = {w_link_word, 2'b00};

endmodule

`default_nettype wire
